// File: rtl/wb_lsu_master_if.sv
// -----------------------------------------------------------------------------
// wb_lsu_master_if
// Wishbone classic single-beat bus between the load/store master and the data
// memory slave. The signal names are written from the master's side, so _o is a
// master output and _i is a master input.
//
// Signals:
//   wb_adr_o  byte address            wb_dat_o  lane-replicated write data
//   wb_sel_o  byte lane enables       wb_we_o   write enable
//   wb_stb_o  strobe                  wb_cyc_o  cycle
//   wb_dat_i  read data               wb_ack_i  acknowledge
// Modports: master (drives adr/dat_o/sel/we/stb/cyc), slave (drives dat_i/ack).
// -----------------------------------------------------------------------------
interface wb_lsu_master_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0] wb_adr_o;
    logic [DATA_WIDTH-1:0] wb_dat_o;
    logic [3:0]            wb_sel_o;
    logic                  wb_we_o;
    logic                  wb_stb_o;
    logic                  wb_cyc_o;
    logic [DATA_WIDTH-1:0] wb_dat_i;
    logic                  wb_ack_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
        output wb_dat_i, wb_ack_i
    );
endinterface

// File: rtl/wb_lsu_master.sv
// -----------------------------------------------------------------------------
// wb_lsu_master
// Wishbone classic initiator between the core load/store stage and the
// byte-addressed data memory. Accepts one byte/half/word request at a time,
// rejects misaligned requests without touching the bus, drives byte lane
// enables and lane-replicated store data, runs one single-beat cycle and
// returns sign/zero-extended load data as a one-cycle response pulse.
//
// Optional feature macro: WB_TIMEOUT_EN
//   defined   : the ack wait is bounded by TIMEOUT_CYCLES bus cycles; on expiry
//               the cycle is dropped and an error response is returned.
//   undefined : the bus cycle waits for ack indefinitely.
//
// Parameters: DATA_WIDTH (32 only), ADDR_WIDTH, TIMEOUT_CYCLES.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid_i/req_ready_o  request handshake (ready is the only combinational output)
//   req_we_i, req_addr_i, req_wdata_i, req_size_i, req_unsigned_i  request fields
//   rsp_valid_o, rsp_rdata_o, rsp_err_o  one-cycle response
//   wb                Wishbone master modport
// -----------------------------------------------------------------------------
module wb_lsu_master #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    wb_lsu_master_if.master       wb
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Size 11 is reserved and always treated as misaligned.
    function automatic logic is_misaligned(input logic [1:0] a, input logic [1:0] size);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = a[0];
            2'b10:   bad = (a != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_sel(input logic [1:0] a, input logic [1:0] size);
        logic [3:0] sel;
        case (size)
            2'b00:   sel = 4'b0001 << a;
            2'b01:   sel = 4'b0011 << {a[1], 1'b0};
            2'b10:   sel = 4'b1111;
            default: sel = 4'b0000;
        endcase
        return sel;
    endfunction

    // Store data is replicated across every lane so the slave can pick any lane.
    function automatic logic [31:0] lane_dat(input logic [31:0] w, input logic [1:0] size);
        logic [31:0] d;
        case (size)
            2'b00:   d = {4{w[7:0]}};
            2'b01:   d = {2{w[15:0]}};
            2'b10:   d = w;
            default: d = 32'h0000_0000;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] d, input logic [1:0] a,
                                                 input logic [1:0] size, input logic uns);
        logic [31:0] x;
        logic [31:0] r;
        x = d >> {a, 3'b000};
        case (size)
            2'b00:   r = uns ? {24'h00_0000, x[7:0]} : {{24{x[7]}}, x[7:0]};
            2'b01:   r = uns ? {16'h0000, x[15:0]}   : {{16{x[15]}}, x[15:0]};
            default: r = x;
        endcase
        return r;
    endfunction

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [3:0]            sel_q, sel_d;
    logic                  we_q, we_d;
    logic                  stb_q, stb_d;
    logic                  cyc_q, cyc_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    logic accept_s;
    logic misalign_s;
    logic timeout_s;

    assign req_ready_o = (state_q == ST_IDLE) && !rst;
    assign accept_s    = req_valid_i && req_ready_o;
    assign misalign_s  = is_misaligned(req_addr_i[1:0], req_size_i);

`ifdef WB_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Ack-wait counter: held at zero outside a bus cycle, so every BUS entry starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_BUS && !wb.wb_ack_i) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (state_q == ST_BUS) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // Ack-wait counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expires on the BUS cycle whose increment would reach TIMEOUT_CYCLES; an ack in that cycle wins.
    assign timeout_s = (state_q == ST_BUS) && !wb.wb_ack_i &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // No timeout in this build; TIMEOUT_CYCLES only appears here.
    assign timeout_s = (TIMEOUT_CYCLES == 0) & 1'b0;
`endif

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            adr_q       <= {ADDR_WIDTH{1'b0}};
            dat_q       <= {DATA_WIDTH{1'b0}};
            sel_q       <= 4'b0000;
            we_q        <= 1'b0;
            stb_q       <= 1'b0;
            cyc_q       <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {DATA_WIDTH{1'b0}};
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            stb_q       <= stb_d;
            cyc_q       <= cyc_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = misalign_s ? ST_RESP : ST_BUS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (wb.wb_ack_i || timeout_s) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_BUS;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered bus and response outputs.
    always_comb begin
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        we_d        = we_q;
        stb_d       = stb_q;
        cyc_d       = cyc_q;
        size_d      = size_q;
        uns_d       = uns_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = {DATA_WIDTH{1'b0}};
        rsp_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    adr_d  = req_addr_i;
                    size_d = req_size_i;
                    uns_d  = req_unsigned_i;
                    if (misalign_s) begin
                        // Rejected without a bus cycle: error response next cycle.
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        dat_d = lane_dat(req_wdata_i, req_size_i);
                        sel_d = lane_sel(req_addr_i[1:0], req_size_i);
                        we_d  = req_we_i;
                        stb_d = 1'b1;
                        cyc_d = 1'b1;
                    end
                end else begin
                    rsp_valid_d = 1'b0;
                end
            end
            ST_BUS: begin
                if (wb.wb_ack_i) begin
                    sel_d       = 4'b0000;
                    we_d        = 1'b0;
                    stb_d       = 1'b0;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    if (we_q) begin
                        rsp_rdata_d = {DATA_WIDTH{1'b0}};
                    end else begin
                        rsp_rdata_d = load_extract(wb.wb_dat_i, adr_q[1:0], size_q, uns_q);
                    end
                end else if (timeout_s) begin
                    sel_d       = 4'b0000;
                    we_d        = 1'b0;
                    stb_d       = 1'b0;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    stb_d = stb_q;
                end
            end
            ST_RESP: rsp_valid_d = 1'b0;
            default: begin
                sel_d = 4'b0000;
                we_d  = 1'b0;
                stb_d = 1'b0;
                cyc_d = 1'b0;
            end
        endcase
    end

    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_sel_o = sel_q;
    assign wb.wb_we_o  = we_q;
    assign wb.wb_stb_o = stb_q;
    assign wb.wb_cyc_o = cyc_q;

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule
